// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state encoding and constants for the peripheral MMIO bridge
package mmio_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} mmio_state_t;
  localparam logic [15:0] MMIO_WINDOW_HI = 16'h3FF5;
  localparam int MMIO_DEFAULT_TIMEOUT = 16;
  localparam int MMIO_ERR_W = 8;
endpackage

// File: rtl/mmio_timeout_ctr.sv
// mmio_timeout_ctr: counts WAIT cycles, expired flags the last allowed one
module mmio_timeout_ctr import mmio_pkg::*; #(
  parameter int TIMEOUT_CYCLES = MMIO_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt;
  assign expired = cnt == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: single-outstanding CPU request to peripheral bus bridge with read timeout
module mmio_bridge import mmio_pkg::*; #(
  parameter int TIMEOUT_CYCLES = MMIO_DEFAULT_TIMEOUT,
  parameter logic [15:0] WINDOW_HI = MMIO_WINDOW_HI
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [31:0]           req_addr_in,
  input  logic [31:0]           req_wdata_in,
  input  logic                  req_we_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [31:0]           resp_rdata_out,
  output logic                  resp_err_out,
  output logic [MMIO_ERR_W-1:0] err_count_out,
  output logic [31:0]           addr_out,
  output logic [31:0]           data_out,
  output logic                  wr_out,
  output logic                  rd_out,
  input  logic                  rd_valid_in,
  input  logic [31:0]           data_in
);
  mmio_state_t state, state_nxt;
  logic hs, in_win, expired, enter_resp, rsp_err;
  logic [31:0] rsp_rdata;
  assign hs = req_valid_in && req_ready_out;
  assign in_win = req_addr_in[31:16] == WINDOW_HI;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !hs ? IDLE : !in_win ? RESP : req_we_in ? WRITE : READ;
      WRITE:   state_nxt = RESP;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = (rd_valid_in || expired) ? RESP : WAIT;
      RESP:    state_nxt = resp_ready_in ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // Only IDLE (out-of-window) and a silent WAIT can enter RESP with an error
  assign enter_resp = state_nxt == RESP && state != RESP;
  assign rsp_err = state == IDLE || (state == WAIT && !rd_valid_in);
  assign rsp_rdata = (state == WAIT && rd_valid_in) ? data_in : '0;
  mmio_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(state == READ),
    .enable(state == WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      req_ready_out  <= 1'b0;
      resp_valid_out <= 1'b0;
      resp_rdata_out <= '0;
      resp_err_out   <= 1'b0;
      err_count_out  <= '0;
      addr_out       <= '0;
      data_out       <= '0;
      wr_out         <= 1'b0;
      rd_out         <= 1'b0;
    end else begin
      req_ready_out  <= state_nxt == IDLE;
      resp_valid_out <= state_nxt == RESP;
      wr_out         <= state_nxt == WRITE;
      rd_out         <= state_nxt == READ;
      if (hs && in_win) addr_out <= req_addr_in;
      if (hs && in_win && req_we_in) data_out <= req_wdata_in;
      if (enter_resp) begin
        resp_rdata_out <= rsp_rdata;
        resp_err_out   <= rsp_err;
      end
      if (enter_resp && rsp_err && err_count_out != '1) err_count_out <= err_count_out + 1'b1;
    end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

- Single-outstanding bridge between the CPU load/store port and the memory-mapped peripheral bus used by the timer and its siblings.
- Accepts one request at a time over a valid/ready handshake and decodes the 0x3FF5_xxxx peripheral window.
- Converts each in-window request into a one-cycle `wr`/`rd` strobe with address and data held stable, then waits for `rd_valid` on reads, bounded by a timeout.
- Returns every transaction as a response with an error flag; out-of-window requests never touch the bus.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent waiting for `rd_valid_in`; legal range 1–255.
- `WINDOW_HI`, default 16'h3FF5: value of `addr[31:16]` that selects the peripheral bus.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid_in` in 1: CPU request valid.
- `req_ready_out` out 1: bridge can accept a request.
- `req_addr_in` in 32: request byte address.
- `req_wdata_in` in 32: write data.
- `req_we_in` in 1: 1 = write, 0 = read.
- `resp_valid_out` out 1: response valid.
- `resp_ready_in` in 1: CPU accepts the response.
- `resp_rdata_out` out 32: read data; 0 for writes and errors.
- `resp_err_out` out 1: out-of-window access or read timeout.
- `err_count_out` out 8: saturating count of error responses.
- `addr_out` out 32: peripheral address.
- `data_out` out 32: peripheral write data.
- `wr_out` out 1: peripheral write strobe.
- `rd_out` out 1: peripheral read strobe.
- `rd_valid_in` in 1: peripheral read data valid.
- `data_in` in 32: peripheral read data.

## Operation
- All outputs are registered. While `rst` is asserted, every output is 0 and the state is IDLE. On the first rising edge after release, `req_ready_out` goes to 1.
- **IDLE:** `req_ready_out` = 1. A handshake occurs on an edge where `req_valid_in` and `req_ready_out` are both 1; the bridge latches address, data and `we`, and `req_ready_out` drops to 0.
  - `addr[31:16]` ≠ `WINDOW_HI` → RESP with `err`=1 and `rdata`=0. No strobe is issued.
  - In-window write → WRITE.
  - In-window read → READ.
- **WRITE:** `wr_out`=1 for exactly one cycle, with `addr_out`/`data_out` valid in that cycle. Then → RESP with `err`=0 and `rdata`=0.
- **READ:** `rd_out`=1 for exactly one cycle, with `addr_out` valid. Then → WAIT and clear the timeout counter.
- **WAIT:** `addr_out` held. `rd_valid_in` is sampled each cycle.
  - When `rd_valid_in` = 1, capture `data_in` → RESP with `err`=0.
  - Otherwise the counter increments. After `TIMEOUT_CYCLES` WAIT cycles without valid → RESP with `err`=1 and `rdata`=0.
  - `rd_valid_in` in the final WAIT cycle wins over the timeout.
- **RESP:** `resp_valid_out`=1, with `rdata` and `err` stable until the edge where `resp_ready_in`=1. Then → IDLE and `req_ready_out`=1.
- `rd_valid_in` outside WAIT is ignored and never produces a response.
- `addr_out` and `data_out` retain their last values between transactions. `wr_out`/`rd_out` are 0 in every state except WRITE/READ.
- `err_count_out` increments on entry to RESP with `err`=1, and saturates at 255.
- Asserting reset mid-transaction aborts it immediately: strobes drop and no response is produced.

## Timing
- Handshake at edge n:
  - Write: `wr_out` high in cycle n+1; `resp_valid_out` high from cycle n+2.
  - Read from a peripheral with a registered 1-cycle response: `rd_out` high in cycle n+1, `rd_valid_in` in cycle n+2, `resp_valid_out` from cycle n+3.
  - Out-of-window: `resp_valid_out` from cycle n+1.
  - Read timeout: `resp_valid_out` from cycle n+2+`TIMEOUT_CYCLES`.
- Back-to-back throughput: one response accepted in cycle m gives `req_ready_out`=1 in cycle m+1. The minimum turnaround for consecutive writes is 3 cycles.
- Peripherals must have a read latency of at least 1 cycle; a `rd_valid_in` asserted in the same cycle as `rd_out` is ignored.

## Structure
- Shared package `mmio_pkg`:
  - State enum `mmio_state_t` (IDLE, WRITE, READ, WAIT, RESP).
  - `MMIO_WINDOW_HI` = 16'h3FF5.
  - `MMIO_DEFAULT_TIMEOUT` = 16.
  - Error-count width constant.
- One sub-module, `mmio_timeout_ctr`, with `clear`/`enable`/`expired` controls and width `$clog2(TIMEOUT_CYCLES+1)`.
- FSM, request/response registers and error counter live in the top module.

## Test plan
- Write to 0x3FF5_F000 with data 0x8000_0000, `resp_ready_in` tied 1 → `wr_out` pulses one cycle with `addr_out`=0x3FF5_F000 and `data_out`=0x8000_0000. Response with `err`=0 arrives 2 cycles after the handshake.
- Read of 0x3FF5_F000 against a timer model that returns 0x8000_0000 one cycle after `rd_out` → `resp_rdata_out`=0x8000_0000, `err`=0, response at n+3.
- Read with a silent peripheral and `TIMEOUT_CYCLES`=4 → `err`=1, `rdata`=0 at n+6, `err_count_out`=1. Repeat with valid on the 4th WAIT cycle → `err`=0.
- Write to 0x1000_0000 → no `wr_out`/`rd_out` ever, `err`=1 at n+1. After 300 such writes, `err_count_out`=255.
- `resp_ready_in` held 0 for 5 cycles → response fields stable, `req_ready_out`=0, new `req_valid_in` not accepted. A stray `rd_valid_in` during RESP causes no change.
- Assert `rst` during WAIT → all outputs 0 asynchronously. After release, `req_ready_out`=1 on the first edge and no stale response appears.
